ahb_interconnect_n: RTL

- Parametrised successor to the fixed 1-manager/3-subordinate AHB-Lite interconnect.
- One CPU-side manager port fans out to NUM_SLV subordinates, using a parameter-defined base/mask address map.
- Adds two functions to the SoC fabric:
  - a built-in default subordinate that returns a two-cycle ERROR on unmapped addresses;
  - a per-subordinate wait-state watchdog that aborts and quarantines a hung peripheral (camera, NPU, output unit).

---
 rtl/ahb_interconnect_n.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_interconnect_n.sv
// AHB-Lite 1:N interconnect with a built-in default (ERROR) subordinate,
// a per-subordinate wait-state watchdog and sticky quarantine of hung peripherals.
module ahb_interconnect_n #(
  parameter int unsigned                  NUM_SLV  = 3,
  parameter int unsigned                  ADDR_W   = 32,
  parameter int unsigned                  DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_BASE = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_MASK = {3{32'hFFFF_F000}},
  parameter int unsigned                  TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           s_haddr_i,
  input  logic                        s_hwrite_i,
  input  logic [2:0]                  s_hsize_i,
  input  logic [2:0]                  s_hburst_i,
  input  logic [3:0]                  s_hprot_i,
  input  logic [1:0]                  s_htrans_i,
  input  logic                        s_hmastlock_i,
  input  logic [DATA_W-1:0]           s_hwdata_i,
  output logic                        s_hready_o,
  output logic                        s_hresp_o,
  output logic [DATA_W-1:0]           s_hrdata_o,
  output logic [NUM_SLV-1:0]          m_hsel_o,
  output logic [ADDR_W-1:0]           m_haddr_o,
  output logic                        m_hwrite_o,
  output logic [2:0]                  m_hsize_o,
  output logic [2:0]                  m_hburst_o,
  output logic [3:0]                  m_hprot_o,
  output logic [1:0]                  m_htrans_o,
  output logic                        m_hmastlock_o,
  output logic [DATA_W-1:0]           m_hwdata_o,
  output logic                        m_hready_o,
  input  logic [NUM_SLV-1:0]          m_hreadyout_i,
  input  logic [NUM_SLV-1:0]          m_hresp_i,
  input  logic [NUM_SLV*DATA_W-1:0]   m_hrdata_i,
  output logic [NUM_SLV-1:0]          quarantine_o,
  output logic                        decode_err_o,
  input  logic [NUM_SLV-1:0]          qclr_i
);

  localparam logic [1:0]        ST_OK    = 2'd0;
  localparam logic [1:0]        ST_ERR1  = 2'd1;
  localparam logic [1:0]        ST_ERR2  = 2'd2;
  localparam bit                WDOG_EN  = (TIMEOUT > 0);
  localparam int unsigned       CNT_W    = WDOG_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned       CNT_LIM  = WDOG_EN ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_LIM);

  // owner_q is one-hot SLV(i); all-zero means NONE in ST_OK and DEF in the error states
  logic [1:0]          state_q, state_d;
  logic [NUM_SLV-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SLV-1:0]  quar_q, quar_d;
  logic                decerr_q, decerr_d;

  logic [NUM_SLV-1:0]  match_c, hit_c;
  logic                active_c, any_hit_c, stall_c, timeout_c;
  logic                own_rdy_c, own_rsp_c, hready_c;
  logic [DATA_W-1:0]   own_rdata_c;

  // Address decode: quarantined subordinates never match, lowest index wins
  always_comb begin
    match_c = '0;
    hit_c   = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      match_c[i] = ((s_haddr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                   && !quar_q[i];
    end
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (match_c[i]) begin
        hit_c    = '0;
        hit_c[i] = 1'b1;
      end
    end
  end

  assign active_c  = s_htrans_i[1];
  assign any_hit_c = |hit_c;

  assign m_hsel_o      = (active_c && !reset) ? hit_c : '0;
  assign m_haddr_o     = s_haddr_i;
  assign m_hwrite_o    = s_hwrite_i;
  assign m_hsize_o     = s_hsize_i;
  assign m_hburst_o    = s_hburst_i;
  assign m_hprot_o     = s_hprot_i;
  assign m_htrans_o    = s_htrans_i;
  assign m_hmastlock_o = s_hmastlock_i;
  assign m_hwdata_o    = s_hwdata_i;

  // Response of the subordinate owning the data phase (NONE gives an OKAY idle)
  always_comb begin
    own_rdy_c   = 1'b1;
    own_rsp_c   = 1'b0;
    own_rdata_c = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (owner_q[i]) begin
        own_rdy_c   = m_hreadyout_i[i];
        own_rsp_c   = m_hresp_i[i];
        own_rdata_c = m_hrdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hready_c   = own_rdy_c;
    s_hresp_o  = own_rsp_c;
    s_hrdata_o = own_rdata_c;
    case (state_q)
      ST_ERR1: begin
        hready_c   = 1'b0;
        s_hresp_o  = 1'b1;
        s_hrdata_o = '0;
      end
      ST_ERR2: begin
        hready_c   = 1'b1;
        s_hresp_o  = 1'b1;
        s_hrdata_o = '0;
      end
      default: ;
    endcase
  end

  assign s_hready_o   = hready_c;
  assign m_hready_o   = hready_c;
  assign quarantine_o = quar_q;
  assign decode_err_o = decerr_q;

  assign stall_c   = |(owner_q & ~m_hreadyout_i);
  assign timeout_c = WDOG_EN && stall_c && (cnt_q == CNT_LAST);

  // Next state: watchdog abort overrides everything, else owner follows accepted address phases
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = '0;
    quar_d   = quar_q;
    decerr_d = 1'b0;

    if (WDOG_EN && stall_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (qclr_i[i] && m_hreadyout_i[i] && !owner_q[i]) begin
        quar_d[i] = 1'b0;
      end
    end

    if (timeout_c) begin
      quar_d  = quar_d | owner_q;
      cnt_d   = '0;
      owner_d = '0;
      state_d = ST_ERR1;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (hready_c) begin
      if (active_c && any_hit_c) begin
        owner_d = hit_c;
        state_d = ST_OK;
      end else if (active_c) begin
        owner_d  = '0;
        state_d  = ST_ERR1;
        decerr_d = 1'b1;
      end else begin
        owner_d = '0;
        state_d = ST_OK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_OK;
      owner_q  <= '0;
      cnt_q    <= '0;
      quar_q   <= '0;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      quar_q   <= quar_d;
      decerr_q <= decerr_d;
    end
  end

endmodule
